pcie_arbitro_rr: RTL and testbench

- Round-robin arbiter between the four virtual-channel FIFOs (VC0..VC3) and the four output FIFOs that drive data_out4..data_out7 in the PCIE transaction block.
- Each cycle it pops at most one word from a non-empty VC FIFO.
- The destination is decoded from the word header, and the word is pushed into the matching output FIFO unless that FIFO's almost_full is set.
- It holds per-destination push counters that the probador reads through req/idx.

---
 rtl/pcie_pkg.sv | 17 +
 rtl/pcie_rr_sel.sv | 28 ++
 rtl/pcie_arbitro_rr.sv | 128 ++++++++++++
 tb/tb_pcie_arbitro_rr.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// Shared constants for the PCIE VC-to-output round-robin arbiter.
// Header field positions, channel counts and FSM state encodings.
package pcie_pkg;

  // Destination field bit positions, counted down from the word width (bit W-DEST_HI .. W-DEST_LO).
  localparam int DEST_HI  = 1;
  localparam int DEST_LO  = 2;

  localparam int N_VC     = 4;
  localparam int N_OUT    = 4;
  localparam int IDX_BASE = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] INIT   = 2'd2;

endpackage

// File: rtl/pcie_rr_sel.sv
// Four-way rotating priority select: first set bit of elig starting at ptr wins.
module pcie_rr_sel
  import pcie_pkg::*;
(
  input  logic [N_VC-1:0] elig,
  input  logic [1:0]      ptr,
  output logic [N_VC-1:0] gnt,
  output logic [1:0]      gnt_idx
);

  always_comb begin
    logic [1:0] cand;
    logic       hit;
    gnt_idx = ptr;
    hit     = 1'b0;
    cand    = ptr;
    // Walk from the farthest candidate back to ptr so the nearest eligible one is kept.
    for (int k = N_VC - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (elig[cand]) begin
        gnt_idx = cand;
        hit     = 1'b1;
      end
    end
    gnt = hit ? (4'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/pcie_arbitro_rr.sv
// Round-robin arbiter moving words from VC0..VC3 FIFOs into out4..out7 FIFOs,
// with saturating per-destination push counters readable through req/idx.
module pcie_arbitro_rr
  import pcie_pkg::*;
#(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [N_VC-1:0]         vc_empty,
  input  logic [TAMANO_DATOS-1:0] vc_data0,
  input  logic [TAMANO_DATOS-1:0] vc_data1,
  input  logic [TAMANO_DATOS-1:0] vc_data2,
  input  logic [TAMANO_DATOS-1:0] vc_data3,
  input  logic [N_OUT-1:0]        out_almost_full,
  output logic [N_VC-1:0]         vc_pop,
  output logic [N_OUT-1:0]        push_out,
  output logic [TAMANO_DATOS-1:0] data_arb,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [CNT_W-1:0]        contador,
  output logic                    valid_contador
);

  logic [1:0]              state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [N_OUT-1:0]        push_out_q, push_out_d;
  logic [TAMANO_DATOS-1:0] data_arb_q, data_arb_d;
  logic [CNT_W-1:0]        cnt_q [N_OUT];
  logic [CNT_W-1:0]        cnt_d [N_OUT];
  logic [CNT_W-1:0]        contador_q, contador_d;
  logic                    valid_contador_q, valid_contador_d;

  logic [TAMANO_DATOS-1:0] vc_data [N_VC];
  logic [1:0]              dest [N_VC];
  logic [N_VC-1:0]         elig, gnt;
  logic [1:0]              gnt_idx;
  logic                    pop_en, clr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign vc_data[0] = vc_data0;
  assign vc_data[1] = vc_data1;
  assign vc_data[2] = vc_data2;
  assign vc_data[3] = vc_data3;

  always_comb begin
    for (int i = 0; i < N_VC; i++) begin
      dest[i] = vc_data[i][TAMANO_DATOS-DEST_HI : TAMANO_DATOS-DEST_LO];
      elig[i] = !vc_empty[i] && !out_almost_full[dest[i]] && (state_q != INIT);
    end
  end

  pcie_rr_sel u_sel (
    .elig    (elig),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // init wins over any grant computed in the same cycle.
  assign pop_en = (state_q == ACTIVE) && !init;
  assign clr    = init || (state_q == INIT);
  assign vc_pop = pop_en ? gnt : '0;

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    push_out_d       = '0;
    data_arb_d       = data_arb_q;
    contador_d       = contador_q;
    valid_contador_d = req;

    if (pop_en && (|gnt)) begin
      push_out_d = 4'(1) << dest[gnt_idx];
      data_arb_d = vc_data[gnt_idx];
      ptr_d      = gnt_idx + 2'd1;
    end
    if (clr) ptr_d = '0;

    for (int d = 0; d < N_OUT; d++) begin
      if (clr)                cnt_d[d] = '0;
      else if (push_out_q[d]) cnt_d[d] = sat_inc(cnt_q[d]);
      else                    cnt_d[d] = cnt_q[d];
    end

    // Readout sees the counter before this edge's increment.
    if (req) contador_d = (idx >= 3'(IDX_BASE)) ? cnt_q[idx[1:0]] : '0;

    case (state_q)
      IDLE:    if (|elig) state_d = ACTIVE;
      ACTIVE:  if (!(|elig)) state_d = IDLE;
      INIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (init) state_d = INIT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      ptr_q            <= '0;
      push_out_q       <= '0;
      data_arb_q       <= '0;
      contador_q       <= '0;
      valid_contador_q <= 1'b0;
      for (int d = 0; d < N_OUT; d++) cnt_q[d] <= '0;
    end else begin
      state_q          <= state_d;
      ptr_q            <= ptr_d;
      push_out_q       <= push_out_d;
      data_arb_q       <= data_arb_d;
      contador_q       <= contador_d;
      valid_contador_q <= valid_contador_d;
      for (int d = 0; d < N_OUT; d++) cnt_q[d] <= cnt_d[d];
    end
  end

  assign push_out       = push_out_q;
  assign data_arb       = data_arb_q;
  assign contador       = contador_q;
  assign valid_contador = valid_contador_q;

endmodule

// File: tb/tb_pcie_arbitro_rr.sv
// Directed bench for pcie_arbitro_rr: queue-based VC FIFOs, a per-cycle
// behavioural reference and hand-computed checkpoints.
module tb_pcie_arbitro_rr;

  localparam int W  = 12;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic          req = 1'b0;
  logic [2:0]    idx = 3'd0;
  logic [3:0]    vc_empty;
  logic [3:0]    out_almost_full = 4'b0;
  logic [W-1:0]  vc_data0, vc_data1, vc_data2, vc_data3;
  logic [3:0]    vc_pop, push_out;
  logic [W-1:0]  data_arb;
  logic [CW-1:0] contador;
  logic          valid_contador;

  pcie_arbitro_rr #(.TAMANO_DATOS(W), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .vc_empty        (vc_empty),
    .vc_data0        (vc_data0),
    .vc_data1        (vc_data1),
    .vc_data2        (vc_data2),
    .vc_data3        (vc_data3),
    .out_almost_full (out_almost_full),
    .vc_pop          (vc_pop),
    .push_out        (push_out),
    .data_arb        (data_arb),
    .req             (req),
    .idx             (idx),
    .contador        (contador),
    .valid_contador  (valid_contador)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // VC FIFOs as queues, show-ahead head on vc_dataN
  logic [W-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [3:0]   pop_s = 4'b0;

  task automatic refresh();
    vc_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    vc_data0 = (q0.size() > 0) ? q0[0] : '0;
    vc_data1 = (q1.size() > 0) ? q1[0] : '0;
    vc_data2 = (q2.size() > 0) ? q2[0] : '0;
    vc_data3 = (q3.size() > 0) ? q3[0] : '0;
  endtask

  function automatic logic [W-1:0] mkw(input int d, input int p);
    return {d[1:0], p[9:0]};
  endfunction

  task automatic push_vc(input int vc, input logic [W-1:0] w);
    case (vc)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic clear_vcs();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  function automatic logic [W-1:0] head(input int vc);
    case (vc)
      0: return vc_data0;
      1: return vc_data1;
      2: return vc_data2;
      default: return vc_data3;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (pop_s[0] && q0.size() > 0) void'(q0.pop_front());
        if (pop_s[1] && q1.size() > 0) void'(q1.pop_front());
        if (pop_s[2] && q2.size() > 0) void'(q2.pop_front());
        if (pop_s[3] && q3.size() > 0) void'(q3.pop_front());
      end
      refresh();
    end
  end

  // Reference: mode 0=idle 1=active 2=init; values are what the registers hold now.
  int           m_mode, m_ptr, m_cont;
  int           m_cnt [4];
  logic [3:0]   m_push;
  logic [W-1:0] m_data;
  logic         m_valid;

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_cont = 0; m_push = '0; m_data = '0; m_valid = 1'b0;
    for (int d = 0; d < 4; d++) m_cnt[d] = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int         g, c, dst;
    logic [3:0] elig, exp_pop;
    logic       clear;
    if (reset) begin
      model_reset();
      pop_s = '0;
      check("rst_vc_pop", vc_pop, 0);
      check("rst_push_out", push_out, 0);
      check("rst_data_arb", data_arb, 0);
      check("rst_contador", contador, 0);
      check("rst_valid", valid_contador, 0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        dst = int'(head(i) >> (W - 2));
        elig[i] = !vc_empty[i] && !out_almost_full[dst] && (m_mode != 2);
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && elig[c]) g = c;
      end
      exp_pop = (m_mode == 1 && !init && g >= 0) ? (4'b1 << g) : 4'b0;

      check("vc_pop", vc_pop, exp_pop);
      check("push_out", push_out, m_push);
      check("data_arb", data_arb, m_data);
      check("valid_contador", valid_contador, m_valid);
      check("contador", contador, m_cont);
      pop_s = vc_pop;

      clear = init || (m_mode == 2);
      if (req) begin
        m_valid = 1'b1;
        m_cont  = (idx >= 3'd4) ? m_cnt[idx - 3'd4] : 0;
      end else begin
        m_valid = 1'b0;
      end
      for (int d = 0; d < 4; d++) begin
        if (clear) m_cnt[d] = 0;
        else if (m_push[d]) m_cnt[d] = (m_cnt[d] + 1 > 31) ? 31 : m_cnt[d] + 1;
      end
      if (exp_pop != 0) begin
        m_data = head(g);
        m_push = 4'b1 << int'(m_data >> (W - 2));
        m_ptr  = (g + 1) % 4;
      end else begin
        m_push = '0;
      end
      if (clear) m_ptr = 0;
      if (init) m_mode = 2;
      else if (m_mode == 2) m_mode = 0;
      else m_mode = (elig != 0) ? 1 : 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic at_neg_pop(input string name, input logic [3:0] exp);
    @(negedge clk);
    check(name, vc_pop, exp);
  endtask

  initial begin
    int found;
    refresh();
    step(3);
    reset = 1'b0;
    step(2);

    // 1: one word per VC, destinations 0..3
    for (int i = 0; i < 4; i++) push_vc(i, mkw(i, 16 + i));
    refresh();
    at_neg_pop("t1_idle", 4'b0000);
    at_neg_pop("t1_vc0", 4'b0001);
    at_neg_pop("t1_vc1", 4'b0010);
    check("t1_push0", push_out, 4'b0001);
    check("t1_data0", data_arb, mkw(0, 16));
    at_neg_pop("t1_vc2", 4'b0100);
    check("t1_push1", push_out, 4'b0010);
    at_neg_pop("t1_vc3", 4'b1000);
    check("t1_push2", push_out, 4'b0100);
    at_neg_pop("t1_none", 4'b0000);
    check("t1_push3", push_out, 4'b1000);
    check("t1_data3", data_arb, mkw(3, 19));
    step(3);

    // 2: VC1 and VC3 both backlogged from ptr=0
    for (int i = 0; i < 4; i++) begin
      push_vc(1, mkw(1, 32 + i));
      push_vc(3, mkw(3, 48 + i));
    end
    refresh();
    at_neg_pop("t2_idle", 4'b0000);
    at_neg_pop("t2_a", 4'b0010);
    at_neg_pop("t2_b", 4'b1000);
    at_neg_pop("t2_c", 4'b0010);
    at_neg_pop("t2_d", 4'b1000);
    step(8);

    // 3: VC0 targets almost-full out6, VC2 targets out5
    out_almost_full = 4'b0100;
    push_vc(0, mkw(2, 64));
    push_vc(2, mkw(1, 65));
    refresh();
    at_neg_pop("t3_idle", 4'b0000);
    at_neg_pop("t3_vc2", 4'b0100);
    at_neg_pop("t3_blk", 4'b0000);
    check("t3_push", push_out, 4'b0010);
    at_neg_pop("t3_blk2", 4'b0000);
    @(posedge clk);
    #2;
    out_almost_full = 4'b0000;
    at_neg_pop("t3_idle2", 4'b0000);
    at_neg_pop("t3_vc0", 4'b0001);
    step(4);

    // 4: clear counters, three pushes to out5, read back
    init = 1'b1;
    step(1);
    init = 1'b0;
    step(2);
    for (int i = 0; i < 3; i++) push_vc(0, mkw(1, 80 + i));
    refresh();
    step(8);
    req = 1'b1; idx = 3'd5;
    step(1);
    check("t4_valid5", valid_contador, 1);
    check("t4_cnt5", contador, 3);
    idx = 3'd2;
    step(1);
    check("t4_valid2", valid_contador, 1);
    check("t4_cnt2", contador, 0);
    req = 1'b0;
    step(1);
    check("t4_valid_off", valid_contador, 0);

    // 5: saturation, then init suppressing an active grant
    for (int i = 0; i < 40; i++) push_vc(0, mkw(0, i));
    refresh();
    step(50);
    req = 1'b1; idx = 3'd4;
    step(1);
    check("t5_sat", contador, 31);
    req = 1'b0;
    for (int i = 0; i < 3; i++) push_vc(1, mkw(1, 100 + i));
    refresh();
    at_neg_pop("t5_idle", 4'b0000);
    at_neg_pop("t5_pop", 4'b0010);
    @(posedge clk);
    #2;
    init = 1'b1;
    at_neg_pop("t5_init_rise", 4'b0000);
    @(posedge clk);
    #2;
    at_neg_pop("t5_init_hold", 4'b0000);
    @(posedge clk);
    #2;
    init = 1'b0;
    step(6);
    req = 1'b1; idx = 3'd4;
    step(1);
    check("t5_cleared", contador, 0);
    check("t5_cleared_v", valid_contador, 1);
    req = 1'b0;
    step(2);

    // 6: reset right after a pop
    for (int i = 0; i < 4; i++) push_vc(i, mkw(i, 200 + i));
    refresh();
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (vc_pop != 0) found = 1;
    end
    check("t6_pop_seen", found, 1);
    @(posedge clk);
    #2;
    check("t6_push_before", (push_out != 0), 1);
    reset = 1'b1;
    clear_vcs();
    refresh();
    #1;
    check("t6_push_async", push_out, 0);
    check("t6_data_async", data_arb, 0);
    step(1);
    reset = 1'b0;
    step(1);
    req = 1'b1; idx = 3'd6;
    step(1);
    check("t6_cnt_clr", contador, 0);
    req = 1'b0;
    for (int i = 0; i < 4; i++) push_vc(i, mkw(i, 220 + i));
    refresh();
    at_neg_pop("t6_idle", 4'b0000);
    at_neg_pop("t6_vc0_first", 4'b0001);
    step(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
